button_gesture: RTL and testbench
=================================

# button_gesture

Classifies a debounced push-button level into single-cycle gesture events: short press, double press and long press, plus a held level for long presses. It sits directly downstream of the `debouncer` (HOLD="TRUE"), so its input is a clean, clock-synchronous level. It feeds the delay-setting control logic: short/double press step the delay, and long press/held drive fast adjust.

## Interface
- `LONG_PERIOD`, 50000000: cycles a first press must be held to count as a long press; ≥2.
- `DOUBLE_WINDOW`, 25000000: cycles after a release during which a second press makes a double press; ≥2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `button` input 1: debounced level, synchronous to `clk`, 1 = pressed.
- `short_press` output 1: one-cycle pulse for a single short press.
- `double_press` output 1: one-cycle pulse for two presses within the window.
- `long_press` output 1: one-cycle pulse when a first press reaches `LONG_PERIOD`.
- `held` output 1: level that is high from `long_press` until release.

## Operation
- Reset values: all outputs 0, state DISARMED, counter 0.
- States come from a 3-bit enum: DISARMED, IDLE, PRESSED1, LONG, WAIT2, PRESSED2.
- DISARMED: on `button`=0, go to IDLE. This blocks a false gesture when the button is held through reset release.
- IDLE: on `button`=1, go to PRESSED1 and clear the counter.
- PRESSED1:
  - If `button`=0, go to WAIT2 and clear the counter.
  - Else if counter==`LONG_PERIOD`-1, pulse `long_press`, set `held`, go to LONG.
  - Else increment the counter.
- LONG: `held`=1. On `button`=0, clear `held` and go to IDLE. No other events are emitted.
- WAIT2:
  - If `button`=1, go to PRESSED2.
  - Else if counter==`DOUBLE_WINDOW`-1, pulse `short_press` and go to IDLE.
  - Else increment the counter.
- PRESSED2: on `button`=0, pulse `double_press` and go to IDLE. The press duration is unbounded and the counter is idle.
- Priority rules:
  - Release beats long-press expiry on the same edge.
  - Re-press beats window expiry on the same edge.
- Counter:
  - Width is `$clog2(max(LONG_PERIOD, DOUBLE_WINDOW))`, unsigned.
  - It never wraps, because every terminal compare resets or leaves the counting state.
- At most one of `short_press`, `double_press` and `long_press` is high in any cycle.
- Unused state encodings fall back to DISARMED.

## Timing
- All outputs are registered and update on the same edge as the state. There is no combinational input-to-output path.
- Edge E0 is the first edge that samples `button`=1 in IDLE.
  - `long_press` is high for exactly the cycle after edge E0+`LONG_PERIOD`, if `button` stays 1 through that edge.
  - `held` rises with `long_press` and falls on the edge after `button` is sampled 0.
- Edge R is the edge that samples the release in PRESSED1.
  - `short_press` is high in the cycle after edge R+`DOUBLE_WINDOW`, unless a re-press is sampled at R+1..R+`DOUBLE_WINDOW`.
- `double_press` is high in the cycle after the edge that samples the second release.
- Asserting `resetn` mid-gesture clears pulses and `held` immediately (asynchronously). No event is emitted for the interrupted gesture.

## Structure
- Package `button_gesture_pkg` holds the `state_e` enum, so the control logic can observe the state in assertions.
- No sub-module is needed. Implement as a single module with one comb next-state block and one async-reset `always_ff` block.

## Test plan
All scenarios use `LONG_PERIOD`=8 and `DOUBLE_WINDOW`=4.
- Reset release with `button`=1 held for 20 cycles, then released → no pulses and `held`=0 throughout. A following 2-cycle press gives `short_press` 4 edges after its release edge.
- Press for 3 cycles, release, wait 10 cycles → exactly one `short_press`, in the cycle after edge R+4. `double_press`=`long_press`=0.
- Press 3 cycles, release 2 cycles, press 2 cycles, release → one `double_press` in the cycle after the second release edge, and no `short_press`.
- Press held 15 cycles → `long_press` for one cycle after edge E0+8, then `held`=1 until the edge after release. No `short_press` follows.
- Boundaries:
  - Release sampled at the edge where counter==7 → no `long_press`, and `short_press` follows.
  - Re-press sampled at the edge where counter==3 in WAIT2 → `double_press`, not `short_press`.
- Assert `resetn`=0 for 1 cycle while `held`=1 and `button`=1 → `held` clears during reset, state is DISARMED, and no pulse appears until the button is released and pressed again.

Source files
------------

// File: rtl/button_gesture_pkg.sv
// Shared types for the button gesture classifier.
package button_gesture_pkg;

  // Classifier states; encodings 6 and 7 are unused and recover to DISARMED.
  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    IDLE     = 3'd1,
    PRESSED1 = 3'd2,
    LONG     = 3'd3,
    WAIT2    = 3'd4,
    PRESSED2 = 3'd5
  } state_e;

endpackage

// File: rtl/button_gesture.sv
// Turns a debounced button level into short/double/long press pulses and a held level.
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int unsigned LONG_PERIOD   = 50000000,
  parameter int unsigned DOUBLE_WINDOW = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic button,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic held
);

  localparam int unsigned MAX_PERIOD = (LONG_PERIOD > DOUBLE_WINDOW) ? LONG_PERIOD : DOUBLE_WINDOW;
  localparam int unsigned CNT_W      = $clog2(MAX_PERIOD);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PERIOD - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(DOUBLE_WINDOW - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             short_d;
  logic             double_d;
  logic             long_d;
  logic             held_d;

  // Next state, counter and output events; release/re-press take priority over expiry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    held_d   = 1'b0;
    case (state_q)
      DISARMED: begin
        if (!button) state_d = IDLE;
      end
      IDLE: begin
        if (button) begin
          state_d = PRESSED1;
          cnt_d   = '0;
        end
      end
      PRESSED1: begin
        if (!button) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          held_d  = 1'b1;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (!button) state_d = IDLE;
        else         held_d  = 1'b1;
      end
      WAIT2: begin
        if (button) begin
          state_d = PRESSED2;
        end else if (cnt_q == WINDOW_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED2: begin
        if (!button) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  // State, counter and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= DISARMED;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      double_press <= double_d;
      long_press   <= long_d;
      held         <= held_d;
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Scoreboard bench for button_gesture with LONG_PERIOD=8, DOUBLE_WINDOW=4.
module tb_button_gesture;
  import button_gesture_pkg::*;

  localparam logic [3:0] EV_SHORT  = 4'b1000;
  localparam logic [3:0] EV_DOUBLE = 4'b0100;
  localparam logic [3:0] EV_LONG   = 4'b0010;
  localparam logic [3:0] EV_HELD   = 4'b0001;

  logic clk = 1'b0;
  logic resetn;
  logic button;
  logic short_press;
  logic double_press;
  logic long_press;
  logic held;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: button level per cycle and the outputs required after that edge.
  logic       pat_q[$];
  logic [3:0] exp_q[$];

  button_gesture #(
    .LONG_PERIOD  (8),
    .DOUBLE_WINDOW(4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .button      (button),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .held        (held)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic lvl);
    repeat (n) begin
      pat_q.push_back(lvl);
      exp_q.push_back(4'b0000);
    end
  endtask

  task automatic expect_at(input int idx, input logic [3:0] v);
    exp_q[idx] = exp_q[idx] | v;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    resetn = 1'b0;
    button = 1'b1;
    #12;
    got = {short_press, double_press, long_press, held};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000", got);
    end
    n_checks++;
    if (dut.state_q !== DISARMED) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, DISARMED);
    end
    @(negedge clk);
    resetn = 1'b1;
    pat_q.delete();
    exp_q.delete();
    add(20, 1'b1);              // held through reset release
    add(3, 1'b0);               // idx 20..22
    add(2, 1'b1);               // idx 23..24, E0 = 23
    add(8, 1'b0);               // R = 25
    expect_at(29, EV_SHORT);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_short_press();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(3, 1'b1);               // E0 = 0
    add(10, 1'b0);              // R = 3
    expect_at(7, EV_SHORT);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL short_press cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_double_press();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(3, 1'b1);
    add(2, 1'b0);               // R = 3
    add(2, 1'b1);               // re-press at 5
    add(7, 1'b0);               // second release at 7
    expect_at(7, EV_DOUBLE);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL double_press cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_long_press();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(15, 1'b1);              // E0 = 0
    add(8, 1'b0);               // release sampled at 15
    expect_at(8, EV_LONG);
    for (int k = 8; k <= 14; k++) expect_at(k, EV_HELD);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL long_press cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_long_boundary();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(8, 1'b1);               // edges 0..7, counter reaches 7
    add(7, 1'b0);               // release at edge 8 beats expiry, R = 8
    expect_at(12, EV_SHORT);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL long_boundary cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_window_boundary();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(3, 1'b1);
    add(4, 1'b0);               // R = 3, counter 3 at edge 7
    add(2, 1'b1);               // re-press at edge 7 = R+4 beats expiry
    add(6, 1'b0);               // second release at 9
    expect_at(9, EV_DOUBLE);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL window_boundary cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] got;
    logic [3:0] want;
    int i;
    pat_q.delete();
    exp_q.delete();
    add(10, 1'b1);
    expect_at(8, EV_LONG);
    expect_at(8, EV_HELD);
    expect_at(9, EV_HELD);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_hold_setup cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    got = {short_press, double_press, long_press, held};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_hold_async_clear: got %b want 0000", got);
    end
    n_checks++;
    if (dut.state_q !== DISARMED) begin
      n_fail++;
      $display("FAIL mid_hold_state: got %0d want %0d", dut.state_q, DISARMED);
    end
    @(negedge clk);
    resetn = 1'b1;
    pat_q.delete();
    exp_q.delete();
    add(5, 1'b1);               // still held after reset: ignored
    add(2, 1'b0);               // idx 5..6
    add(2, 1'b1);               // E0 = 7
    add(7, 1'b0);               // R = 9
    expect_at(13, EV_SHORT);
    i = 0;
    while (pat_q.size() > 0) begin
      @(negedge clk);
      button = pat_q.pop_front();
      @(posedge clk);
      #1;
      got  = {short_press, double_press, long_press, held};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_hold_after cycle %0d: got %b want %b", i, got, want);
      end
      i++;
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_short_press();
    test_double_press();
    test_long_press();
    test_long_boundary();
    test_window_boundary();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
